// File: rtl/wmc_pkg.sv
// Shared definitions for the wash-cycle sequencer: state codes seen by the cycle timer,
// motor speed codes and small state-decode helpers.
package wmc_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StLock      = 3'd1,
        StFillWater = 3'd2,
        StHeatWater = 3'd3,
        StWash      = 3'd4,
        StRinse     = 3'd5,
        StSpin      = 3'd6,
        StComplete  = 3'd7
    } state_t;

    localparam logic [1:0] MOTOR_OFF    = 2'd0;
    localparam logic [1:0] MOTOR_TUMBLE = 2'd1;
    localparam logic [1:0] MOTOR_SPIN   = 2'd3;

    // States that wait on a timer response (fill through spin).
    function automatic logic is_timed(state_t s);
        return (s >= StFillWater) && (s <= StSpin);
    endfunction

    function automatic logic [1:0] motor_for(state_t s);
        logic [1:0] speed;
        speed = MOTOR_OFF;
        if (s == StWash || s == StRinse) speed = MOTOR_TUMBLE;
        if (s == StSpin)                 speed = MOTOR_SPIN;
        return speed;
    endfunction

endpackage

// File: rtl/wmc_watchdog.sv
// Per-state residency counter: clears on a state change, counts in timed states,
// saturates, and flags expiry on the last allowed cycle when no response arrives.
module wmc_watchdog #(
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    input  logic i_response,
    output logic o_expire
);

    localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CntW-1:0] Last = CntW'(WDOG_CYCLES - 1);

    logic [CntW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != Last)) begin
            r_count <= r_count + CntW'(1);
        end
    end

    assign o_expire = i_count && (r_count == Last) && !i_response;

endmodule

// File: rtl/wash_controller.sv
// Wash-cycle sequencer driving the timer state bus and the actuators (registered decode).
// Define WMC_WATCHDOG_EN to add the per-state watchdog fault.
module wash_controller
    import wmc_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       door_closed,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       water_valve,
    output logic       heater,
    output logic [1:0] motor_speed,
    output logic       drain,
    output logic       door_lock,
    output logic       done,
    output logic       fault
);

    state_t     r_state;
    state_t     w_next;
    logic       r_fault;
    logic       w_fault_next;
    logic       r_cmpl_prev;
    logic       w_response;
    logic       w_expire;
    logic       w_timed;
    logic       w_state_change;
    logic       r_water_valve;
    logic       r_heater;
    logic [1:0] r_motor_speed;
    logic       r_drain;
    logic       r_door_lock;
    logic       r_done;

    assign w_timed        = is_timed(r_state);
    assign w_state_change = (w_next != r_state);

    // Completed must be re-qualified by a rising edge so a held pulse advances only one step.
    always_comb begin
        w_response = 1'b0;
        case (r_state)
            StFillWater:             w_response = sig_Full;
            StHeatWater:             w_response = sig_Temperature;
            StWash, StRinse, StSpin: w_response = sig_Completed && !r_cmpl_prev;
            default:                 w_response = 1'b0;
        endcase
    end

`ifdef WMC_WATCHDOG_EN
    wmc_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_state_change),
        .i_count   (w_timed),
        .i_response(w_response),
        .o_expire  (w_expire)
    );
`else
    logic w_unused_wdog;
    assign w_unused_wdog = (WDOG_CYCLES != 0);
    assign w_expire      = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_fault_next = r_fault;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_fault_next = 1'b0;
                    if (door_closed && !cancel) w_next = StLock;
                end
            end
            StLock: begin
                w_next = (door_closed && !cancel) ? StFillWater : StIdle;
            end
            StComplete: begin
                if (!door_closed) w_next = StIdle;
            end
            default: begin
                if (!door_closed || w_expire) begin
                    w_next       = StIdle;
                    w_fault_next = 1'b1;
                end else if (cancel) begin
                    w_next = StIdle;
                end else if (w_response) begin
                    w_next = state_t'(r_state + 3'd1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_fault       <= 1'b0;
            r_cmpl_prev   <= 1'b0;
            r_water_valve <= 1'b0;
            r_heater      <= 1'b0;
            r_motor_speed <= MOTOR_OFF;
            r_drain       <= 1'b0;
            r_door_lock   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_fault       <= w_fault_next;
            r_cmpl_prev   <= sig_Completed;
            r_water_valve <= (w_next == StFillWater);
            r_heater      <= (w_next == StHeatWater);
            r_motor_speed <= motor_for(w_next);
            r_drain       <= (w_next == StRinse) || (w_next == StSpin);
            r_door_lock   <= (w_next >= StLock) && (w_next <= StSpin);
            r_done        <= (w_next == StComplete);
        end
    end

    assign state       = r_state;
    assign fault       = r_fault;
    assign water_valve = r_water_valve;
    assign heater      = r_heater;
    assign motor_speed = r_motor_speed;
    assign drain       = r_drain;
    assign door_lock   = r_door_lock;
    assign done        = r_done;

endmodule
